// File: rtl/jzjpcc_redirect_ctrl_if.sv
// rtl/jzjpcc_redirect_ctrl_if.sv - execute-stage redirect bus between pipeline and redirect controller
interface jzjpcc_redirect_ctrl_if;
    logic        exValid;
    logic        exIsBranch;
    logic        exIsJal;
    logic        exIsJalr;
    logic [2:0]  funct3;
    logic [31:0] rs1Value;
    logic [31:0] rs2Value;
    logic [31:0] immediate;
    logic [31:2] exPC;
    logic        fetchStall;
    logic        pcWriteEnable;
    logic [31:2] newPC;
    logic        flushFetch;
    logic        flushDecode;
    logic        misalignedTarget;
    logic [31:0] redirectCount;

    // Pipeline side: drives the execute-stage instruction, receives the redirect
    modport master (
        output exValid, exIsBranch, exIsJal, exIsJalr, funct3,
        output rs1Value, rs2Value, immediate, exPC, fetchStall,
        input  pcWriteEnable, newPC, flushFetch, flushDecode,
        input  misalignedTarget, redirectCount
    );

    // Controller side
    modport slave (
        input  exValid, exIsBranch, exIsJal, exIsJalr, funct3,
        input  rs1Value, rs2Value, immediate, exPC, fetchStall,
        output pcWriteEnable, newPC, flushFetch, flushDecode,
        output misalignedTarget, redirectCount
    );
endinterface

// File: rtl/jzjpcc_redirect_ctrl.sv
// rtl/jzjpcc_redirect_ctrl.sv - branch/jump resolution and PC redirect controller with stall hold-off
module jzjpcc_redirect_ctrl (
    input  logic               clock,
    input  logic               reset,
    jzjpcc_redirect_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state;
    logic [31:2] pending_pc;
    logic        misaligned_q;
    logic [31:0] count_q;

    logic        condition;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic        redirect_now;

    logic        pc_we;
    logic [31:2] new_pc;
    logic        flush;

    // Evaluate the branch condition selected by funct3; reserved encodings never take
    always_comb begin
        condition = 1'b0;
        case (bus.funct3)
            3'b000:  condition = (bus.rs1Value == bus.rs2Value);
            3'b001:  condition = (bus.rs1Value != bus.rs2Value);
            3'b100:  condition = ($signed(bus.rs1Value) <  $signed(bus.rs2Value));
            3'b101:  condition = ($signed(bus.rs1Value) >= $signed(bus.rs2Value));
            3'b110:  condition = (bus.rs1Value <  bus.rs2Value);
            3'b111:  condition = (bus.rs1Value >= bus.rs2Value);
            default: condition = 1'b0;
        endcase
    end

    // Resolve direction and target; jalr outranks jal, which outranks branch
    always_comb begin
        target = '0;
        taken  = 1'b0;
        if (bus.exIsJalr) begin
            target = (bus.rs1Value + bus.immediate) & 32'hFFFF_FFFE;
            taken  = bus.exValid;
        end else if (bus.exIsJal) begin
            target = {bus.exPC, 2'b00} + bus.immediate;
            taken  = bus.exValid;
        end else if (bus.exIsBranch) begin
            target = {bus.exPC, 2'b00} + bus.immediate;
            taken  = bus.exValid & condition;
        end
    end

    // Bit 0 is already cleared, so only bit 1 can make a word target misaligned
    assign misaligned   = target[1];
    assign redirect_now = (state == IDLE) && taken && !misaligned;

    // Redirect outputs are combinational so the PC sees the target in the resolving cycle;
    // reset forces them quiet even though the execute inputs may look taken
    always_comb begin
        pc_we  = 1'b0;
        new_pc = '0;
        flush  = 1'b0;
        if (!reset) begin
            if (state == PENDING) begin
                pc_we  = 1'b1;
                new_pc = pending_pc;
                flush  = 1'b1;
            end else if (redirect_now) begin
                pc_we  = 1'b1;
                new_pc = target[31:2];
                flush  = 1'b1;
            end
        end
    end

    // FSM: hold a stalled redirect until the PC accepts it, count accepted redirects,
    // and pulse the misaligned trap for one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending_pc   <= '0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            misaligned_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (taken && misaligned) begin
                        misaligned_q <= 1'b1;
                    end else if (redirect_now) begin
                        if (bus.fetchStall) begin
                            pending_pc <= target[31:2];
                            state      <= PENDING;
                        end else begin
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                PENDING: begin
                    if (!bus.fetchStall) begin
                        count_q <= count_q + 32'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pcWriteEnable    = pc_we;
    assign bus.newPC            = new_pc;
    assign bus.flushFetch       = flush;
    assign bus.flushDecode      = flush;
    assign bus.misalignedTarget = misaligned_q;
    assign bus.redirectCount    = count_q;

endmodule

// File: tb/tb_jzjpcc_redirect_ctrl.sv
// tb/tb_jzjpcc_redirect_ctrl.sv - directed self-checking bench for jzjpcc_redirect_ctrl
module tb_jzjpcc_redirect_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] exp_count;

    jzjpcc_redirect_ctrl_if bus ();

    jzjpcc_redirect_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc_byte, input logic stall);
        bus.exValid    = v;
        bus.exIsBranch = br;
        bus.exIsJal    = jal;
        bus.exIsJalr   = jalr;
        bus.funct3     = f3;
        bus.rs1Value   = a;
        bus.rs2Value   = b;
        bus.immediate  = imm;
        bus.exPC       = pc_byte[31:2];
        bus.fetchStall = stall;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.flushFetch !== 1'b0 || bus.newPC !== 30'd0) begin
            $display("FAIL reset_outputs: pcWriteEnable=%b flushFetch=%b newPC=%h expected 0/0/0",
                     bus.pcWriteEnable, bus.flushFetch, bus.newPC);
            errors++;
        end
        checks++;
        if (bus.redirectCount !== 32'd0 || bus.misalignedTarget !== 1'b0) begin
            $display("FAIL reset_regs: redirectCount=%h misalignedTarget=%b expected 0/0",
                     bus.redirectCount, bus.misalignedTarget);
            errors++;
        end
        exp_count = 32'd0;
    endtask

    task automatic test_beq_taken();
        @(negedge clock);
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h100, 1'b0);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h3E ||
            bus.flushFetch !== 1'b1 || bus.flushDecode !== 1'b1) begin
            $display("FAIL beq_redirect: pcWriteEnable=%b newPC=%h flushes=%b%b expected 1/3e/11",
                     bus.pcWriteEnable, bus.newPC, bus.flushFetch, bus.flushDecode);
            errors++;
        end
        @(posedge clock);
        #1;
        set_idle();
        exp_count = exp_count + 1;
        checks++;
        if (bus.redirectCount !== exp_count) begin
            $display("FAIL beq_count: redirectCount=%0d expected %0d", bus.redirectCount, exp_count);
            errors++;
        end
    endtask

    task automatic test_bltu_blt();
        @(negedge clock);
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.flushFetch !== 1'b0 ||
            bus.flushDecode !== 1'b0 || bus.newPC !== 30'd0) begin
            $display("FAIL bltu_not_taken: pcWriteEnable=%b flushes=%b%b newPC=%h expected 0/00/0",
                     bus.pcWriteEnable, bus.flushFetch, bus.flushDecode, bus.newPC);
            errors++;
        end
        @(negedge clock);
        bus.funct3 = 3'b100;
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h48) begin
            $display("FAIL blt_taken: pcWriteEnable=%b newPC=%h expected 1/48",
                     bus.pcWriteEnable, bus.newPC);
            errors++;
        end
        @(posedge clock);
        #1;
        set_idle();
        exp_count = exp_count + 1;
        checks++;
        if (bus.redirectCount !== exp_count) begin
            $display("FAIL blt_count: redirectCount=%0d expected %0d", bus.redirectCount, exp_count);
            errors++;
        end
    endtask

    task automatic test_conditions();
        logic [2:0]  f3s  [7] = '{3'b001, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011, 3'b000};
        logic [31:0] as   [7] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5};
        logic [31:0] bs   [7] = '{32'd6, 32'd5, 32'd1, 32'd1, 32'd5, 32'd5, 32'd6};
        logic        exps [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            set_ex(1'b1, 1'b1, 1'b0, 1'b0, f3s[i], as[i], bs[i], 32'd0, 32'h40, 1'b0);
            #1;
            checks++;
            if (bus.pcWriteEnable !== exps[i] || bus.flushFetch !== exps[i] ||
                bus.newPC !== (exps[i] ? 30'h10 : 30'h0)) begin
                $display("FAIL cond_%0d: funct3=%b pcWriteEnable=%b flushFetch=%b newPC=%h expected taken=%b",
                         i, f3s[i], bus.pcWriteEnable, bus.flushFetch, bus.newPC, exps[i]);
                errors++;
            end
            @(posedge clock);
            #1;
            if (exps[i]) exp_count = exp_count + 1;
            checks++;
            if (bus.redirectCount !== exp_count) begin
                $display("FAIL cond_count_%0d: redirectCount=%0d expected %0d", i, bus.redirectCount, exp_count);
                errors++;
            end
        end
        set_idle();
    endtask

    task automatic test_priority();
        @(negedge clock);
        set_ex(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h2000, 32'd0, 32'd4, 32'h10, 1'b0);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h801) begin
            $display("FAIL jalr_priority: pcWriteEnable=%b newPC=%h expected 1/801",
                     bus.pcWriteEnable, bus.newPC);
            errors++;
        end
        @(negedge clock);
        bus.exIsJalr = 1'b0;
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h5) begin
            $display("FAIL jal_over_branch: pcWriteEnable=%b newPC=%h expected 1/5",
                     bus.pcWriteEnable, bus.newPC);
            errors++;
        end
        @(posedge clock);
        #1;
        set_idle();
        exp_count = exp_count + 2;
        checks++;
        if (bus.redirectCount !== exp_count) begin
            $display("FAIL priority_count: redirectCount=%0d expected %0d", bus.redirectCount, exp_count);
            errors++;
        end
    endtask

    task automatic test_misaligned();
        @(negedge clock);
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.flushFetch !== 1'b0 || bus.misalignedTarget !== 1'b0) begin
            $display("FAIL misaligned_same_cycle: pcWriteEnable=%b flushFetch=%b misalignedTarget=%b expected 0/0/0",
                     bus.pcWriteEnable, bus.flushFetch, bus.misalignedTarget);
            errors++;
        end
        @(posedge clock);
        #1;
        set_idle();
        checks++;
        if (bus.misalignedTarget !== 1'b1 || bus.redirectCount !== exp_count) begin
            $display("FAIL misaligned_pulse: misalignedTarget=%b redirectCount=%0d expected 1/%0d",
                     bus.misalignedTarget, bus.redirectCount, exp_count);
            errors++;
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.misalignedTarget !== 1'b0) begin
            $display("FAIL misaligned_one_cycle: misalignedTarget=%b expected 0", bus.misalignedTarget);
            errors++;
        end
    endtask

    task automatic test_stall_pending();
        @(negedge clock);
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10, 32'h200, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h1000, 1'b1);
            end else if (c == 2) begin
                set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h0, 1'b1);
            end else if (c == 3) begin
                set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h1000, 1'b0);
            end
            #1;
            checks++;
            if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h84 ||
                bus.flushFetch !== 1'b1 || bus.flushDecode !== 1'b1) begin
                $display("FAIL stall_hold_%0d: pcWriteEnable=%b newPC=%h flushes=%b%b expected 1/84/11",
                         c, bus.pcWriteEnable, bus.newPC, bus.flushFetch, bus.flushDecode);
                errors++;
            end
            @(posedge clock);
            #1;
            if (c == 3) exp_count = exp_count + 1;
            checks++;
            if (bus.redirectCount !== exp_count || bus.misalignedTarget !== 1'b0) begin
                $display("FAIL stall_count_%0d: redirectCount=%0d misalignedTarget=%b expected %0d/0",
                         c, bus.redirectCount, bus.misalignedTarget, exp_count);
                errors++;
            end
            @(negedge clock);
        end
        set_idle();
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.newPC !== 30'd0) begin
            $display("FAIL stall_release_idle: pcWriteEnable=%b newPC=%h expected 0/0",
                     bus.pcWriteEnable, bus.newPC);
            errors++;
        end
    endtask

    task automatic test_reset_pending();
        @(negedge clock);
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10, 32'h200, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.redirectCount !== 32'd0 || bus.flushFetch !== 1'b0) begin
            $display("FAIL reset_mid_pending: pcWriteEnable=%b redirectCount=%0d flushFetch=%b expected 0/0/0",
                     bus.pcWriteEnable, bus.redirectCount, bus.flushFetch);
            errors++;
        end
        bus.fetchStall = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.newPC !== 30'd0 || bus.redirectCount !== 32'd0) begin
            $display("FAIL reset_held_quiet: pcWriteEnable=%b newPC=%h redirectCount=%0d expected 0/0/0",
                     bus.pcWriteEnable, bus.newPC, bus.redirectCount);
            errors++;
        end
        @(negedge clock);
        set_idle();
        reset = 1'b0;
        exp_count = 32'd0;
        @(posedge clock);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b0 || bus.redirectCount !== 32'd0) begin
            $display("FAIL reset_release_no_redirect: pcWriteEnable=%b redirectCount=%0d expected 0/0",
                     bus.pcWriteEnable, bus.redirectCount);
            errors++;
        end
    endtask

    task automatic test_wrap_target();
        @(negedge clock);
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 1'b0);
        #1;
        checks++;
        if (bus.pcWriteEnable !== 1'b1 || bus.newPC !== 30'h1) begin
            $display("FAIL jal_wrap: pcWriteEnable=%b newPC=%h expected 1/1", bus.pcWriteEnable, bus.newPC);
            errors++;
        end
        @(posedge clock);
        #1;
        set_idle();
        exp_count = exp_count + 1;
        checks++;
        if (bus.redirectCount !== exp_count) begin
            $display("FAIL wrap_count: redirectCount=%0d expected %0d", bus.redirectCount, exp_count);
            errors++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 32'd0;
        reset     = 1'b1;
        set_idle();
        test_reset();
        test_beq_taken();
        test_bltu_blt();
        test_conditions();
        test_priority();
        test_misaligned();
        test_stall_pending();
        test_reset_pending();
        test_wrap_target();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
